// File: rtl/gshare_predictor_state.sv
// gshare_predictor_state
// Global-history (gshare) direction predictor. A table of saturating
// counters is indexed by the fetch PC XOR the speculative global history.
// A speculative GHR advances with each conditional fetch and a committed
// GHR advances with each resolved conditional branch. A pipeline restart
// rolls the speculative GHR back to the committed one. After reset or flush
// a sweep writes weak-not-taken into every entry before predictions start.

module gshare_predictor_state #(
  parameter int PS_SIZE  = 8,
  parameter int GHR_SIZE = 8,
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bpu_flush,
  input  logic [31:0]         fch_pc_nxt,
  input  logic                fch_predict,
  input  logic                fch_valid_r,
  input  logic                fch_is_cond,
  input  logic                wrb_restart,
  input  logic                wrb_update_bpu,
  input  logic                wrb_is_cond,
  input  logic                wrb_was_pred,
  input  logic [CTR_BITS-1:0] wrb_ctr,
  input  logic [GHR_SIZE-1:0] wrb_ghr,
  input  logic [31:0]         wrb_pc,
  input  logic                wrb_direction,
  output logic [CTR_BITS-1:0] fch_pred_ctr,
  output logic                fch_pred_taken,
  output logic [GHR_SIZE-1:0] fch_ghr,
  output logic                ps_ready
);

  localparam int DEPTH = 1 << PS_SIZE;

  // Counter encodings: weak states sit either side of the MSB boundary.
  localparam logic [CTR_BITS-1:0] CTR_WNT  = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_WT   = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_MIN  = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0] CTR_ONE  = {{(CTR_BITS-1){1'b0}}, 1'b1};

  localparam logic [PS_SIZE-1:0]  IDX_ZERO = {PS_SIZE{1'b0}};
  localparam logic [PS_SIZE-1:0]  IDX_ONE  = {{(PS_SIZE-1){1'b0}}, 1'b1};
  localparam logic [PS_SIZE-1:0]  IDX_LAST = {PS_SIZE{1'b1}};
  localparam logic [GHR_SIZE-1:0] GHR_ZERO = {GHR_SIZE{1'b0}};

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Shift one outcome into the LSB of a history register. Written with a
  // shift plus bit insert so a one-bit history simply replaces its bit.
  function automatic logic [GHR_SIZE-1:0] ghr_shift(
    input logic [GHR_SIZE-1:0] ghr,
    input logic                bit_in
  );
    logic [GHR_SIZE-1:0] res;
    res    = ghr << 1'b1;
    res[0] = bit_in;
    return res;
  endfunction

  // Saturating increment on taken, saturating decrement on not-taken.
  function automatic logic [CTR_BITS-1:0] ctr_next(
    input logic [CTR_BITS-1:0] ctr,
    input logic                taken
  );
    logic [CTR_BITS-1:0] res;
    if (taken) begin
      if (ctr == CTR_MAX) begin
        res = ctr;
      end else begin
        res = ctr + CTR_ONE;
      end
    end else begin
      if (ctr == CTR_MIN) begin
        res = ctr;
      end else begin
        res = ctr - CTR_ONE;
      end
    end
    return res;
  endfunction

  state_t              state_r;
  logic [PS_SIZE-1:0]  sweep_idx_r;
  logic [GHR_SIZE-1:0] ghr_spec_r;
  logic [GHR_SIZE-1:0] ghr_arch_r;
  logic [CTR_BITS-1:0] fch_pred_ctr_r;
  logic [GHR_SIZE-1:0] fch_ghr_r;
  logic                ps_ready_r;
  logic [CTR_BITS-1:0] table_r [DEPTH];

  logic                clear_s;
  logic                commit_s;
  logic                spec_shift_s;
  logic [GHR_SIZE-1:0] ghr_arch_nxt_s;
  logic [GHR_SIZE-1:0] ghr_spec_nxt_s;
  logic [PS_SIZE-1:0]  rd_idx_s;
  logic [PS_SIZE-1:0]  upd_idx_s;
  logic [CTR_BITS-1:0] upd_data_s;
  logic                wr_en_s;
  logic [PS_SIZE-1:0]  wr_idx_s;
  logic [CTR_BITS-1:0] wr_data_s;
  logic [CTR_BITS-1:0] rd_data_s;

  // PC bits outside the index field carry no predictor information.
  logic unused_pc_bits_s;
  assign unused_pc_bits_s = ^{fch_pc_nxt[31:PS_SIZE+2], fch_pc_nxt[1:0],
                              wrb_pc[31:PS_SIZE+2], wrb_pc[1:0]};

  assign clear_s  = reset | bpu_flush;
  assign commit_s = wrb_update_bpu & wrb_is_cond;
  assign spec_shift_s = fch_valid_r & fch_is_cond;

  // History is LSB aligned, so the GHR is zero-extended before the XOR.
  assign rd_idx_s  = fch_pc_nxt[PS_SIZE+1:2] ^ PS_SIZE'(ghr_spec_r);
  assign upd_idx_s = wrb_pc[PS_SIZE+1:2] ^ PS_SIZE'(wrb_ghr);

  // Next committed and speculative history; restart wins over a fetch shift
  // and picks up a commit happening in the same cycle.
  always_comb begin
    ghr_arch_nxt_s = ghr_arch_r;
    ghr_spec_nxt_s = ghr_spec_r;
    if (commit_s) begin
      ghr_arch_nxt_s = ghr_shift(ghr_arch_r, wrb_direction);
    end else begin
      ghr_arch_nxt_s = ghr_arch_r;
    end
    if (wrb_restart) begin
      ghr_spec_nxt_s = ghr_arch_nxt_s;
    end else if (spec_shift_s) begin
      ghr_spec_nxt_s = ghr_shift(ghr_spec_r, fch_pred_ctr_r[CTR_BITS-1]);
    end else begin
      ghr_spec_nxt_s = ghr_spec_r;
    end
  end

  // Counter value written back for a resolved conditional branch.
  always_comb begin
    upd_data_s = CTR_WNT;
    if (wrb_was_pred) begin
      upd_data_s = ctr_next(wrb_ctr, wrb_direction);
    end else if (wrb_direction) begin
      upd_data_s = CTR_WT;
    end else begin
      upd_data_s = CTR_WNT;
    end
  end

  // Single table write port shared by the init sweep and branch updates.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = IDX_ZERO;
    wr_data_s = CTR_WNT;
    if (clear_s) begin
      wr_en_s = 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          wr_en_s   = 1'b1;
          wr_idx_s  = sweep_idx_r;
          wr_data_s = CTR_WNT;
        end
        ST_READY: begin
          if (commit_s) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = upd_idx_s;
            wr_data_s = upd_data_s;
          end else begin
            wr_en_s = 1'b0;
          end
        end
        default: begin
          wr_en_s = 1'b0;
        end
      endcase
    end
  end

  // Write-first read: a same-cycle write to the read index is forwarded.
  always_comb begin
    rd_data_s = table_r[rd_idx_s];
    if (wr_en_s && (wr_idx_s == rd_idx_s)) begin
      rd_data_s = wr_data_s;
    end else begin
      rd_data_s = table_r[rd_idx_s];
    end
  end

  // Counter table storage; contents are defined by the sweep, not by reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      table_r[wr_idx_s] <= wr_data_s;
    end
  end

  // Init/ready FSM with the GHRs and registered prediction outputs.
  always_ff @(posedge clk) begin
    if (clear_s) begin
      state_r        <= ST_INIT;
      sweep_idx_r    <= IDX_ZERO;
      ghr_spec_r     <= GHR_ZERO;
      ghr_arch_r     <= GHR_ZERO;
      fch_pred_ctr_r <= CTR_WNT;
      fch_ghr_r      <= GHR_ZERO;
      ps_ready_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          fch_pred_ctr_r <= CTR_WNT;
          fch_ghr_r      <= GHR_ZERO;
          if (sweep_idx_r == IDX_LAST) begin
            state_r    <= ST_READY;
            ps_ready_r <= 1'b1;
          end else begin
            sweep_idx_r <= sweep_idx_r + IDX_ONE;
            ps_ready_r  <= 1'b0;
          end
        end
        ST_READY: begin
          ps_ready_r <= 1'b1;
          ghr_arch_r <= ghr_arch_nxt_s;
          ghr_spec_r <= ghr_spec_nxt_s;
          if (fch_predict) begin
            fch_pred_ctr_r <= rd_data_s;
            fch_ghr_r      <= ghr_spec_r;
          end
        end
        default: begin
          state_r     <= ST_INIT;
          sweep_idx_r <= IDX_ZERO;
          ps_ready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign fch_pred_ctr   = fch_pred_ctr_r;
  assign fch_pred_taken = fch_pred_ctr_r[CTR_BITS-1];
  assign fch_ghr        = fch_ghr_r;
  assign ps_ready       = ps_ready_r;

endmodule

// File: tb/tb_gshare_predictor_state.sv
// Bench for gshare_predictor_state (default parameters). Stimulus pushes
// the expected read response into a queue; a monitor pops and compares one
// cycle later when the read result is presented.

module tb_gshare_predictor_state;

  logic        clk = 1'b0;
  logic        reset;
  logic        bpu_flush;
  logic [31:0] fch_pc_nxt;
  logic        fch_predict;
  logic        fch_valid_r;
  logic        fch_is_cond;
  logic        wrb_restart;
  logic        wrb_update_bpu;
  logic        wrb_is_cond;
  logic        wrb_was_pred;
  logic [1:0]  wrb_ctr;
  logic [7:0]  wrb_ghr;
  logic [31:0] wrb_pc;
  logic        wrb_direction;
  logic [1:0]  fch_pred_ctr;
  logic        fch_pred_taken;
  logic [7:0]  fch_ghr;
  logic        ps_ready;

  typedef struct packed {
    logic [1:0] ctr;
    logic       taken;
    logic [7:0] ghr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic rd_issued  = 1'b0;
  logic rd_valid_q = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  gshare_predictor_state dut (
    .clk            (clk),
    .reset          (reset),
    .bpu_flush      (bpu_flush),
    .fch_pc_nxt     (fch_pc_nxt),
    .fch_predict    (fch_predict),
    .fch_valid_r    (fch_valid_r),
    .fch_is_cond    (fch_is_cond),
    .wrb_restart    (wrb_restart),
    .wrb_update_bpu (wrb_update_bpu),
    .wrb_is_cond    (wrb_is_cond),
    .wrb_was_pred   (wrb_was_pred),
    .wrb_ctr        (wrb_ctr),
    .wrb_ghr        (wrb_ghr),
    .wrb_pc         (wrb_pc),
    .wrb_direction  (wrb_direction),
    .fch_pred_ctr   (fch_pred_ctr),
    .fch_pred_taken (fch_pred_taken),
    .fch_ghr        (fch_ghr),
    .ps_ready       (ps_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Read results appear one edge after the read is issued.
  always @(posedge clk) rd_valid_q <= rd_issued;

  always @(negedge clk) begin
    if (rd_valid_q) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL rd_unexpected: read result with empty scoreboard (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("rd_ctr",   32'(fch_pred_ctr),   32'(mon_e.ctr));
        check("rd_taken", 32'(fch_pred_taken), 32'(mon_e.taken));
        check("rd_ghr",   32'(fch_ghr),        32'(mon_e.ghr));
      end
    end
  end

  task automatic clear_pulses();
    bpu_flush      = 1'b0;
    fch_predict    = 1'b0;
    fch_valid_r    = 1'b0;
    fch_is_cond    = 1'b0;
    wrb_restart    = 1'b0;
    wrb_update_bpu = 1'b0;
    wrb_is_cond    = 1'b0;
    wrb_was_pred   = 1'b0;
    wrb_ctr        = 2'b00;
    wrb_ghr        = 8'h00;
    wrb_pc         = 32'h0;
    wrb_direction  = 1'b0;
    rd_issued      = 1'b0;
  endtask

  // Advance one edge; inputs change #1 after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    clear_pulses();
  endtask

  task automatic do_read(input logic [31:0] pc, input logic [1:0] ectr, input logic [7:0] eghr);
    exp_t e;
    fch_predict = 1'b1;
    fch_pc_nxt  = pc;
    rd_issued   = 1'b1;
    e.ctr   = ectr;
    e.taken = ectr[1];
    e.ghr   = eghr;
    exp_q.push_back(e);
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic [7:0] ghr, input logic was_pred,
                        input logic [1:0] ctr, input logic dir, input logic is_cond);
    wrb_update_bpu = 1'b1;
    wrb_is_cond    = is_cond;
    wrb_was_pred   = was_pred;
    wrb_ctr        = ctr;
    wrb_ghr        = ghr;
    wrb_pc         = pc;
    wrb_direction  = dir;
  endtask

  task automatic read_now(input logic [31:0] pc, input logic [1:0] ectr, input logic [7:0] eghr);
    do_read(pc, ectr, eghr);
    cycle();
  endtask

  task automatic upd_now(input logic [31:0] pc, input logic [7:0] ghr, input logic was_pred,
                         input logic [1:0] ctr, input logic dir, input logic is_cond);
    do_upd(pc, ghr, was_pred, ctr, dir, is_cond);
    cycle();
  endtask

  // Count cycles after a clearing edge until ps_ready is first seen high.
  task automatic wait_ready(input string name);
    int first;
    first = -1;
    for (int i = 1; i <= 400 && first < 0; i++) begin
      cycle();
      if (ps_ready === 1'b1) first = i;
    end
    check(name, 32'(first), 32'd256);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    fch_pc_nxt = 32'h0;
    clear_pulses();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset values (cycle 0)
    check("rst_ctr",   32'(fch_pred_ctr),   32'h1);
    check("rst_taken", 32'(fch_pred_taken), 32'h0);
    check("rst_ghr",   32'(fch_ghr),        32'h0);
    check("rst_ready", 32'(ps_ready),       32'h0);
    wait_ready("init_ready_cycle");

    // Freshly swept entries read weak-not-taken
    read_now(32'h0000_0000, 2'b01, 8'h00);
    read_now(32'h0000_03FC, 2'b01, 8'h00);

    // Allocation of a taken branch at index 0x10
    upd_now(32'h40, 8'h00, 1'b0, 2'b00, 1'b1, 1'b1);
    read_now(32'h40, 2'b10, 8'h00);

    // Saturating increment at index 0x20
    upd_now(32'h80, 8'h00, 1'b1, 2'b10, 1'b1, 1'b1);
    read_now(32'h80, 2'b11, 8'h00);
    upd_now(32'h80, 8'h00, 1'b1, 2'b11, 1'b1, 1'b1);
    read_now(32'h80, 2'b11, 8'h00);
    // Non-conditional update must leave the entry alone
    upd_now(32'h80, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
    read_now(32'h80, 2'b11, 8'h00);

    // Saturating decrement at index 0x30
    upd_now(32'hC0, 8'h00, 1'b1, 2'b01, 1'b0, 1'b1);
    read_now(32'hC0, 2'b00, 8'h00);
    upd_now(32'hC0, 8'h00, 1'b1, 2'b00, 1'b0, 1'b1);
    read_now(32'hC0, 2'b00, 8'h00);

    // Write index uses wrb_ghr: 0x40 ^ 0x05 = 0x45, read back via pc 0x114
    upd_now(32'h100, 8'h05, 1'b0, 2'b00, 1'b1, 1'b1);
    read_now(32'h114, 2'b10, 8'h00);

    // Same-cycle write and read at index 0x50: write-first
    do_upd(32'h140, 8'h00, 1'b1, 2'b10, 1'b1, 1'b1);
    do_read(32'h140, 2'b11, 8'h00);
    cycle();
    cycle();

    // Flush from READY; reads during the sweep are ignored
    bpu_flush = 1'b1;
    cycle();
    check("flush_ready_low", 32'(ps_ready), 32'h0);
    fch_predict = 1'b1;
    fch_pc_nxt  = 32'h40;
    cycle();
    check("init_read_ignored_ctr", 32'(fch_pred_ctr), 32'h1);
    check("init_read_ignored_ghr", 32'(fch_ghr),      32'h0);
    for (int i = 0; i < 99; i++) cycle();
    // Sweep index is now 100: flush again to restart it
    check("sweep100_ready_low", 32'(ps_ready), 32'h0);
    bpu_flush = 1'b1;
    cycle();
    wait_ready("reflush_ready_cycle");

    // Trained entries are cleared back to weak-not-taken
    read_now(32'h40,  2'b01, 8'h00);
    read_now(32'h80,  2'b01, 8'h00);
    read_now(32'h140, 2'b01, 8'h00);

    // Speculative history: train idx 0x10 taken, then walk ghr_arch back to 0
    upd_now(32'h40, 8'h00, 1'b0, 2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      upd_now(32'h200 + 32'(4 * i), 8'h00, 1'b0, 2'b00, 1'b0, 1'b1);
    end
    read_now(32'h40, 2'b10, 8'h00);        // predict 1
    fch_valid_r = 1'b1; fch_is_cond = 1'b1;
    cycle();                               // ghr_spec = 0x01
    read_now(32'h0, 2'b01, 8'h01);         // idx 0x01, predict 0
    fch_valid_r = 1'b1; fch_is_cond = 1'b1;
    cycle();                               // ghr_spec = 0x02
    read_now(32'h48, 2'b10, 8'h02);        // idx 0x12^0x02 = 0x10, predict 1
    fch_valid_r = 1'b1; fch_is_cond = 1'b1;
    cycle();                               // ghr_spec = 0x05
    read_now(32'h0, 2'b01, 8'h05);

    // Restart with no commits rolls back to ghr_arch = 0
    wrb_restart = 1'b1;
    cycle();
    read_now(32'h0, 2'b01, 8'h00);

    // Restart with same-cycle commit (taken) and a competing fetch shift
    wrb_restart = 1'b1;
    fch_valid_r = 1'b1; fch_is_cond = 1'b1;
    do_upd(32'h300, 8'h00, 1'b0, 2'b00, 1'b1, 1'b1);
    cycle();
    read_now(32'h0,   2'b01, 8'h01);
    read_now(32'h304, 2'b10, 8'h01);       // idx 0xC1^0x01 = 0xC0 written above

    cycle();
    cycle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
